// File: rtl/bcd_target_counter_if.sv
// bcd_target_counter_if: handshake/bus bundle for bcd_target_counter.
// The direction signal and its modport entries exist only when the
// BCD_DOWN_COUNT_EN macro is defined.
interface bcd_target_counter_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic                  en;
  logic [4*DIGITS-1:0]   target;
`ifdef BCD_DOWN_COUNT_EN
  logic                  dir;
`endif
  logic [4*DIGITS-1:0]   count;
  logic                  busy;
  logic                  done;
  logic                  err;

`ifdef BCD_DOWN_COUNT_EN
  modport master (output start, en, target, dir, input count, busy, done, err);
  modport slave  (input start, en, target, dir, output count, busy, done, err);
`else
  modport master (output start, en, target, input count, busy, done, err);
  modport slave  (input start, en, target, output count, busy, done, err);
`endif
endinterface

// File: rtl/bcd_target_counter.sv
// bcd_target_counter: packed-BCD counter that runs from a start value to an
// end value and pulses DONE when it gets there.
// Optional feature macro: BCD_DOWN_COUNT_EN (adds DIR and down counting).
// Illegal targets (any digit > 9) are rejected with a one-cycle ERR pulse.
module bcd_target_counter #(
  parameter int DIGITS = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  bcd_target_counter_if.slave        bus
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          state_q;
  logic [W-1:0]    count_q;
  logic [W-1:0]    tgt_q;
  logic            busy_q;
  logic            done_q;
  logic            err_q;
`ifdef BCD_DOWN_COUNT_EN
  logic            dir_q;
`endif

  logic            at_end_d;
  logic [W-1:0]    step_d;
  logic [W-1:0]    load_d;
  logic            tgt_ok_d;

  // True when every digit of v is a legal BCD digit.
  function automatic logic bcd_valid(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        ok = 1'b0;
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

  // BCD increment with ripple carry; all-9s wraps to all-0s.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
          c = 1'b1;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

`ifdef BCD_DOWN_COUNT_EN
  // BCD decrement with ripple borrow; all-0s wraps to all-9s.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
          b = 1'b1;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction
`endif

  // Next-step value, end-of-run detection and load value for the current run.
  always_comb begin
    at_end_d = 1'b0;
    step_d   = count_q;
    load_d   = {W{1'b0}};
    tgt_ok_d = bcd_valid(bus.target);
`ifdef BCD_DOWN_COUNT_EN
    if (dir_q) begin
      at_end_d = (count_q == {W{1'b0}});
      step_d   = bcd_dec(count_q);
    end else begin
      at_end_d = (count_q == tgt_q);
      step_d   = bcd_inc(count_q);
    end
    if (bus.dir) begin
      load_d = bus.target;
    end else begin
      load_d = {W{1'b0}};
    end
`else
    at_end_d = (count_q == tgt_q);
    step_d   = bcd_inc(count_q);
`endif
  end

  // Control FSM with registered COUNT/BUSY/DONE/ERR; START beats everything.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      count_q <= {W{1'b0}};
      tgt_q   <= {W{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef BCD_DOWN_COUNT_EN
      dir_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (bus.start) begin
        if (tgt_ok_d) begin
          tgt_q   <= bus.target;
          count_q <= load_d;
          state_q <= ST_RUN;
          busy_q  <= 1'b1;
`ifdef BCD_DOWN_COUNT_EN
          dir_q   <= bus.dir;
`endif
        end else begin
          err_q <= 1'b1;
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            busy_q <= 1'b0;
          end
          ST_RUN: begin
            if (at_end_d) begin
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else if (bus.en) begin
              count_q <= step_d;
            end else begin
              count_q <= count_q;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.count = count_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_bcd_target_counter.sv
// tb_bcd_target_counter: directed self-checking bench for bcd_target_counter
// (DIGITS=4). Down-count scenario is built only with BCD_DOWN_COUNT_EN.
module tb_bcd_target_counter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  bcd_target_counter_if #(.DIGITS(4)) bus ();

  bcd_target_counter #(.DIGITS(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal to packed 4-digit BCD, by division.
  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int          x;
    x = v;
    r = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++;
    if (bus.count !== 16'h0000 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: count=%h busy=%b done=%b err=%b expected 0000/0/0/0",
               bus.count, bus.busy, bus.done, bus.err);
    end
    tick();
    rst = 1'b0;
  endtask

  // Long up count to 1234 with EN held; first START right after reset.
  task automatic test_count_1234();
    bus.start = 1'b1; bus.target = 16'h1234; bus.en = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.count !== 16'h0000 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL up1234_load: count=%h busy=%b done=%b expected 0000/1/0", bus.count, bus.busy, bus.done);
    end
    for (int n = 1; n <= 1234; n++) begin
      tick();
      checks++;
      if (bus.count !== to_bcd(n) || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL up1234_step: count=%h done=%b busy=%b expected %h/0/1", bus.count, bus.done, bus.busy, to_bcd(n));
      end
    end
    tick();
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.count !== 16'h1234) begin
      errors++;
      $display("FAIL up1234_done: done=%b busy=%b count=%h expected 1/0/1234", bus.done, bus.busy, bus.count);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL up1234_pulse: done=%b expected 0", bus.done);
    end
  endtask

  // IDLE ignores EN: count holds, no pulses.
  task automatic test_idle_hold();
    bus.en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (bus.count !== 16'h1234 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
        errors++;
        $display("FAIL idle_hold: count=%h busy=%b done=%b err=%b expected 1234/0/0/0",
                 bus.count, bus.busy, bus.done, bus.err);
      end
    end
  endtask

  // EN alternating: count advances every other edge, 0099 -> 0100 carry.
  task automatic test_en_toggle();
    int   exp_n;
    logic exp_done;
    logic finished;
    bus.start = 1'b1; bus.target = 16'h0199; bus.en = 1'b0;
    tick();
    bus.start = 1'b0;
    exp_n = 0;
    finished = 1'b0;
    for (int c = 0; c < 1000 && !finished; c++) begin
      bus.en = (c % 2 == 0);
      if (exp_n == 199) begin
        exp_done = 1'b1;
      end else begin
        exp_done = 1'b0;
        if (c % 2 == 0) exp_n++;
      end
      tick();
      checks++;
      if (bus.count !== to_bcd(exp_n) || bus.done !== exp_done) begin
        errors++;
        $display("FAIL en_toggle: count=%h done=%b expected %h/%b", bus.count, bus.done, to_bcd(exp_n), exp_done);
      end
      if (exp_done) finished = 1'b1;
    end
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL en_toggle_timeout: finished=%b expected 1", finished);
    end
  endtask

  // Illegal digit in TARGET: ERR pulse only, nothing else moves.
  task automatic test_err();
    bus.start = 1'b1; bus.target = 16'h12A4; bus.en = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.count !== 16'h0199) begin
      errors++;
      $display("FAIL err_pulse: err=%b busy=%b count=%h expected 1/0/0199", bus.err, bus.busy, bus.count);
    end
    tick();
    checks++;
    if (bus.err !== 1'b0 || bus.busy !== 1'b0 || bus.count !== 16'h0199) begin
      errors++;
      $display("FAIL err_after: err=%b busy=%b count=%h expected 0/0/0199", bus.err, bus.busy, bus.count);
    end
  endtask

  // TARGET of zero finishes on the edge after START.
  task automatic test_zero_target();
    bus.start = 1'b1; bus.target = 16'h0000; bus.en = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.count !== 16'h0000 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL zero_load: count=%h busy=%b done=%b expected 0000/1/0", bus.count, bus.busy, bus.done);
    end
    tick();
    checks++;
    if (bus.count !== 16'h0000 || bus.busy !== 1'b0 || bus.done !== 1'b1) begin
      errors++;
      $display("FAIL zero_done: count=%h busy=%b done=%b expected 0000/0/1", bus.count, bus.busy, bus.done);
    end
  endtask

  // Reset in mid-run: immediate clear, no DONE, fresh start from 0000.
  task automatic test_reset_midrun();
    bus.start = 1'b1; bus.target = 16'h0500; bus.en = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int n = 0; n < 250; n++) tick();
    checks++;
    if (bus.count !== 16'h0250) begin
      errors++;
      $display("FAIL midrun_pre: count=%h expected 0250", bus.count);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.count !== 16'h0000 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL midrun_async: count=%h busy=%b done=%b err=%b expected 0000/0/0/0",
               bus.count, bus.busy, bus.done, bus.err);
    end
    tick();
    checks++;
    if (bus.count !== 16'h0000 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL midrun_held: count=%h busy=%b done=%b expected 0000/0/0", bus.count, bus.busy, bus.done);
    end
    rst = 1'b0;
    bus.start = 1'b1; bus.target = 16'h0002;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.count !== 16'h0000 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL midrun_restart: count=%h busy=%b done=%b expected 0000/1/0", bus.count, bus.busy, bus.done);
    end
    tick(); tick(); tick();
    checks++;
    if (bus.count !== 16'h0002 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL midrun_done: count=%h done=%b busy=%b expected 0002/1/0", bus.count, bus.done, bus.busy);
    end
  endtask

  // START mid-run reloads; only the new run produces DONE.
  task automatic test_restart();
    bus.start = 1'b1; bus.target = 16'h0100; bus.en = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int n = 0; n < 50; n++) tick();
    checks++;
    if (bus.count !== 16'h0050) begin
      errors++;
      $display("FAIL restart_pre: count=%h expected 0050", bus.count);
    end
    bus.start = 1'b1; bus.target = 16'h0003;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.count !== 16'h0000 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL restart_load: count=%h busy=%b done=%b expected 0000/1/0", bus.count, bus.busy, bus.done);
    end
    for (int n = 1; n <= 3; n++) begin
      tick();
      checks++;
      if (bus.count !== to_bcd(n) || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL restart_step: count=%h done=%b expected %h/0", bus.count, bus.done, to_bcd(n));
      end
    end
    tick();
    checks++;
    if (bus.done !== 1'b1 || bus.count !== 16'h0003) begin
      errors++;
      $display("FAIL restart_done: done=%b count=%h expected 1/0003", bus.done, bus.count);
    end
  endtask

  // START on the edge where the end value is reached: restart, no DONE.
  task automatic test_back_to_back();
    bus.start = 1'b1; bus.target = 16'h0002; bus.en = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick();
    checks++;
    if (bus.count !== 16'h0002 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_pre: count=%h busy=%b expected 0002/1", bus.count, bus.busy);
    end
    bus.start = 1'b1; bus.target = 16'h0001;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.count !== 16'h0000 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_restart: count=%h busy=%b done=%b expected 0000/1/0", bus.count, bus.busy, bus.done);
    end
    tick(); tick();
    checks++;
    if (bus.count !== 16'h0001 || bus.done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done: count=%h done=%b expected 0001/1", bus.count, bus.done);
    end
  endtask

`ifdef BCD_DOWN_COUNT_EN
  // Down count from 1000 to 0000 with borrow across digits.
  task automatic test_down_count();
    bus.start = 1'b1; bus.target = 16'h1000; bus.en = 1'b1; bus.dir = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int n = 1000; n >= 0; n--) begin
      checks++;
      if (bus.count !== to_bcd(n) || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL down_step: count=%h done=%b expected %h/0", bus.count, bus.done, to_bcd(n));
      end
      tick();
    end
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.count !== 16'h0000) begin
      errors++;
      $display("FAIL down_done: done=%b busy=%b count=%h expected 1/0/0000", bus.done, bus.busy, bus.count);
    end
    bus.dir = 1'b0;
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.start = 1'b0;
    bus.en = 1'b0;
    bus.target = 16'h0000;
`ifdef BCD_DOWN_COUNT_EN
    bus.dir = 1'b0;
`endif
    #3;
    test_reset();
    test_count_1234();
    test_idle_hold();
    test_en_toggle();
    test_err();
    test_zero_target();
    test_reset_midrun();
    test_restart();
    test_back_to_back();
`ifdef BCD_DOWN_COUNT_EN
    test_down_count();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_target_counter.md
BCD_TARGET_COUNTER -- requirements
Module: bcd_target_counter

Interface
REQ-001 Parameter DIGITS, default 4, number of BCD digits (1..8).
REQ-002 CLK  input  1  clock; all state changes on rising edge.
REQ-003 RST  input  1  asynchronous, active-high reset.
REQ-004 START  input  1  begin/restart a count run.
REQ-005 EN  input  1  count enable; COUNT advances only when EN=1.
REQ-006 TARGET  input  4*DIGITS  packed BCD target, digit 0 in bits [3:0]; sampled only when START=1.
REQ-007 DIR  input  1  0 = up, 1 = down; present only with BCD_DOWN_COUNT_EN; sampled only when START=1.
REQ-008 COUNT  output  4*DIGITS  registered packed BCD count.
REQ-009 BUSY  output  1  registered; 1 while in RUN.
REQ-010 DONE  output  1  registered one-cycle pulse on reaching the end value.
REQ-011 ERR  output  1  registered one-cycle pulse when START is rejected.

Function
REQ-012 States: IDLE, RUN; BUSY=1 iff state is RUN.
REQ-013 START=1 with every TARGET digit <=9, in any state: capture TARGET into internal TGT, load COUNT (0 for up, TARGET for down), enter RUN; DONE=0.
REQ-014 START=1 with any TARGET digit >9: ERR=1 next cycle; state, COUNT and TGT unchanged.
REQ-015 RUN, START=0, end value reached (up: COUNT==TGT; down: COUNT==0): DONE=1 next cycle, enter IDLE, COUNT holds.
REQ-016 RUN, START=0, end value not reached, EN=1: COUNT steps by one in BCD (up: digit 9 -> 0 with carry; down: digit 0 -> 9 with borrow); EN=0 holds COUNT.
REQ-017 Up latency: START sampled at edge k, EN held 1 -> COUNT==T at edge k+T (T in decimal), DONE high for the cycle after edge k+T+1.
REQ-018 TARGET == 0: DONE at edge k+1, no increment.
REQ-019 Wrap: all-9s up -> all-0s, all-0s down -> all-9s; unreachable in a valid run, required for correctness of the step logic.
REQ-020 START coinciding with end value: restart wins; no DONE pulse.
REQ-021 IDLE, START=0: COUNT, TGT held; EN ignored; DONE, ERR 0.
REQ-022 COUNT digits SHALL never hold a value >9.

Reset
REQ-023 RST=1 forces asynchronously: state IDLE, COUNT=0, TGT=0, BUSY=0, DONE=0, ERR=0.
REQ-024 RST asserted mid-run abandons the run; no DONE pulse is generated.
REQ-025 First START is honoured on the first rising edge after RST deasserts.

Configuration
REQ-026 Macro BCD_DOWN_COUNT_EN defined: DIR port exists and down counting per REQ-013/015/016 is supported.
REQ-027 Macro not defined: DIR port absent, block counts up only, all down-count logic removed.

Verification
REQ-028 DIGITS=4, TARGET=0x1234, START pulse, EN=1 -> COUNT 0000..1234 in BCD, DONE pulse at edge k+1235, BUSY falls same edge.
REQ-029 TARGET=0x0199, EN toggled 1/0 alternately -> COUNT advances every other cycle, 0099 -> 0100 carry correct, DONE after 0199.
REQ-030 TARGET=0x12A4 with START -> ERR pulse, BUSY stays 0, COUNT unchanged.
REQ-031 Run to 0x0500, RST asserted at COUNT=0x0250 -> all outputs 0 immediately, no DONE; new START restarts from 0000.
REQ-032 START reasserted with TARGET=0x0003 at COUNT=0x0050 -> COUNT reloads 0000, DONE after 0003 only.
REQ-033 BCD_DOWN_COUNT_EN defined, DIR=1, TARGET=0x1000 -> COUNT 1000, 0999, ... 0000, DONE pulse; DIGITS=1 and 8 builds pass REQ-028 scaled.
